// File: rtl/if_pc_stage.sv
// rtl/if_pc_stage.sv - MIPS instruction-fetch stage: program counter, IF/ID latch, stall/flush/halt control
module if_pc_stage #(
   parameter int                B           = 32,
   parameter logic [B-1:0]      RESET_PC    = '0,
   parameter logic [5:0]        HALT_OPCODE = 6'h3F
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         enable,
   input  logic         stall,
   input  logic         flush,
   input  logic [B-1:0] next_pc_in,
   input  logic [31:0]  instr_in,
   output logic [B-1:0] pc_out,
   output logic [B-1:0] pc_plus4,
   output logic [31:0]  if_id_instr,
   output logic [B-1:0] if_id_pc_plus4,
   output logic         if_id_valid,
   output logic         halted
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t         r_state;
   logic [B-1:0]   r_pc;
   logic [31:0]    r_if_id_instr;
   logic [B-1:0]   r_if_id_pc_plus4;
   logic           r_if_id_valid;

   state_t         w_state_nxt;
   logic [B-1:0]   w_pc_nxt;
   logic [31:0]    w_if_id_instr_nxt;
   logic [B-1:0]   w_if_id_pc_plus4_nxt;
   logic           w_if_id_valid_nxt;
   logic [B-1:0]   w_pc_plus4;
   logic           w_is_halt;

   // PC+4 wraps naturally at the top of the address space
   assign w_pc_plus4 = r_pc + {{(B-3){1'b0}}, 3'd4};
   assign w_is_halt  = (instr_in[31:26] == HALT_OPCODE);

   // State register and IF/ID latch; reset clears everything at once so no partial IF/ID survives
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state          <= S_IDLE;
         r_pc             <= RESET_PC;
         r_if_id_instr    <= '0;
         r_if_id_pc_plus4 <= '0;
         r_if_id_valid    <= 1'b0;
      end else begin
         r_state          <= w_state_nxt;
         r_pc             <= w_pc_nxt;
         r_if_id_instr    <= w_if_id_instr_nxt;
         r_if_id_pc_plus4 <= w_if_id_pc_plus4_nxt;
         r_if_id_valid    <= w_if_id_valid_nxt;
      end
   end

   // Next-state and next-latch selection; flush outranks stall, stall outranks halt detection
   always_comb begin
      w_state_nxt          = r_state;
      w_pc_nxt             = r_pc;
      w_if_id_instr_nxt    = r_if_id_instr;
      w_if_id_pc_plus4_nxt = r_if_id_pc_plus4;
      w_if_id_valid_nxt    = r_if_id_valid;
      case (r_state)
         S_IDLE: begin
            w_if_id_valid_nxt = 1'b0;
            if (enable) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (flush) begin
               w_pc_nxt             = next_pc_in;
               w_if_id_instr_nxt    = '0;
               w_if_id_pc_plus4_nxt = '0;
               w_if_id_valid_nxt    = 1'b0;
            end else if (stall) begin
               w_pc_nxt = r_pc;
            end else if (w_is_halt) begin
               // Halt instruction still goes down the pipe, but fetch freezes on its address
               w_if_id_instr_nxt    = instr_in;
               w_if_id_pc_plus4_nxt = w_pc_plus4;
               w_if_id_valid_nxt    = 1'b1;
               w_state_nxt          = S_HALT;
            end else begin
               w_pc_nxt             = next_pc_in;
               w_if_id_instr_nxt    = instr_in;
               w_if_id_pc_plus4_nxt = w_pc_plus4;
               w_if_id_valid_nxt    = 1'b1;
            end
         end
         S_HALT: begin
            if (flush) begin
               // The halt was on a wrong path; resume fetching at the redirect target
               w_pc_nxt             = next_pc_in;
               w_if_id_instr_nxt    = '0;
               w_if_id_pc_plus4_nxt = '0;
               w_if_id_valid_nxt    = 1'b0;
               w_state_nxt          = S_RUN;
            end else if (!stall) begin
               w_if_id_instr_nxt    = '0;
               w_if_id_pc_plus4_nxt = '0;
               w_if_id_valid_nxt    = 1'b0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign pc_out         = r_pc;
   assign pc_plus4       = w_pc_plus4;
   assign if_id_instr    = r_if_id_instr;
   assign if_id_pc_plus4 = r_if_id_pc_plus4;
   assign if_id_valid    = r_if_id_valid;
   assign halted         = (r_state == S_HALT);

endmodule

// File: tb/tb_if_pc_stage.sv
// tb/tb_if_pc_stage.sv - directed table-driven bench for if_pc_stage
module tb_if_pc_stage;

   logic        clk;
   logic        rst_n, rst2_n;
   logic        enable, stall, flush;
   logic        enable2;
   logic [31:0] next_pc_in, instr_in, pc_out, pc_plus4;
   logic [31:0] if_id_instr, if_id_pc_plus4;
   logic        if_id_valid, halted;
   logic [31:0] next_pc2, instr2, pc_out2, pc_plus4_2;
   logic [31:0] if_id_instr2, if_id_pc_plus4_2;
   logic        if_id_valid2, halted2;

   logic        redir;
   logic [31:0] target;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] HALT_ADDR  = 32'd20;
   localparam logic [31:0] HALT_INSTR = 32'hFC00_0000;

   if_pc_stage #(.B(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .stall(stall), .flush(flush),
      .next_pc_in(next_pc_in), .instr_in(instr_in), .pc_out(pc_out), .pc_plus4(pc_plus4),
      .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4),
      .if_id_valid(if_id_valid), .halted(halted)
   );

   if_pc_stage #(.B(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk(clk), .rst_n(rst2_n), .enable(enable2), .stall(1'b0), .flush(1'b0),
      .next_pc_in(next_pc2), .instr_in(instr2), .pc_out(pc_out2), .pc_plus4(pc_plus4_2),
      .if_id_instr(if_id_instr2), .if_id_pc_plus4(if_id_pc_plus4_2),
      .if_id_valid(if_id_valid2), .halted(halted2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] imem(input logic [31:0] a);
      if (a == HALT_ADDR) return HALT_INSTR;
      return {6'h01, a[25:0]};
   endfunction

   // instruction memory and next-PC mux models
   always_comb begin
      instr_in   = imem(pc_out);
      next_pc_in = redir ? target : pc_plus4;
      instr2     = imem(pc_out2);
      next_pc2   = pc_plus4_2;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        en, st, fl, rd;
      logic [31:0] tgt;
      logic [31:0] e_pc, e_instr, e_pp4;
      logic        e_valid, e_halt;
   } vec_t;

   vec_t v[15];

   task automatic apply_check(input int i);
      enable = v[i].en; stall = v[i].st; flush = v[i].fl;
      redir = v[i].rd; target = v[i].tgt;
      @(posedge clk); #1;
      check($sformatf("v%0d pc", i), pc_out, v[i].e_pc);
      check($sformatf("v%0d pc_plus4", i), pc_plus4, v[i].e_pc + 32'd4);
      check($sformatf("v%0d instr", i), if_id_instr, v[i].e_instr);
      check($sformatf("v%0d ifid_pp4", i), if_id_pc_plus4, v[i].e_pp4);
      check($sformatf("v%0d valid", i), {31'd0, if_id_valid}, {31'd0, v[i].e_valid});
      check($sformatf("v%0d halted", i), {31'd0, halted}, {31'd0, v[i].e_halt});
   endtask

   initial begin
      //         en    st    fl    rd    tgt     pc      instr                   pp4     vld   hlt
      v[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'd0,  32'h0,                  32'd0,  1'b0, 1'b0};
      v[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'd4,  {6'h01, 26'd0},         32'd4,  1'b1, 1'b0};
      v[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'd8,  {6'h01, 26'd4},         32'd8,  1'b1, 1'b0};
      v[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'd8,  {6'h01, 26'd4},         32'd8,  1'b1, 1'b0};
      v[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'd8,  {6'h01, 26'd4},         32'd8,  1'b1, 1'b0};
      v[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'd12, {6'h01, 26'd8},         32'd12, 1'b1, 1'b0};
      v[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'd16, {6'h01, 26'd12},        32'd16, 1'b1, 1'b0};
      v[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h40, 32'h0,                  32'd0,  1'b0, 1'b0};
      v[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h44, {6'h01, 26'h40},        32'h44, 1'b1, 1'b0};
      v[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd20, 32'd20, 32'h0,                  32'd0,  1'b0, 1'b0};
      v[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'd20, 32'hFC00_0000,          32'd24, 1'b1, 1'b1};
      v[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'd20, 32'hFC00_0000,          32'd24, 1'b1, 1'b1};
      v[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'd20, 32'h0,                  32'd0,  1'b0, 1'b1};
      v[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h80, 32'h80, 32'h0,                  32'd0,  1'b0, 1'b0};
      v[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h84, {6'h01, 26'h80},        32'h84, 1'b1, 1'b0};

      rst_n = 1'b0; rst2_n = 1'b0;
      enable = 1'b0; stall = 1'b0; flush = 1'b0; redir = 1'b0; target = '0;
      enable2 = 1'b0;
      #12;
      check("reset pc", pc_out, 32'h0);
      check("reset instr", if_id_instr, 32'h0);
      check("reset ifid_pp4", if_id_pc_plus4, 32'h0);
      check("reset valid", {31'd0, if_id_valid}, 32'd0);
      check("reset halted", {31'd0, halted}, 32'd0);
      check("reset2 pc", pc_out2, 32'hFFFF_FFFC);
      check("reset2 pc_plus4 wrap", pc_plus4_2, 32'h0);
      @(negedge clk);
      rst_n = 1'b1; rst2_n = 1'b1;
      // idle with enable low: nothing moves
      @(posedge clk); #1;
      check("idle pc", pc_out, 32'h0);
      check("idle valid", {31'd0, if_id_valid}, 32'd0);

      for (int i = 0; i < 13; i++) apply_check(i);

      // bubbles behind the halt
      enable = 1'b0; stall = 1'b0; flush = 1'b0; redir = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         check($sformatf("bubble%0d pc", k), pc_out, 32'd20);
         check($sformatf("bubble%0d instr", k), if_id_instr, 32'h0);
         check($sformatf("bubble%0d valid", k), {31'd0, if_id_valid}, 32'd0);
         check($sformatf("bubble%0d halted", k), {31'd0, halted}, 32'd1);
      end

      for (int i = 13; i < 15; i++) apply_check(i);

      // wrap fetch on the high-reset instance
      enable2 = 1'b1;
      @(posedge clk); #1;
      check("wrap idle->run pc", pc_out2, 32'hFFFF_FFFC);
      @(posedge clk); #1;
      check("wrap pc", pc_out2, 32'h0);
      check("wrap ifid_instr", if_id_instr2, 32'h07FF_FFFC);
      check("wrap ifid_pp4", if_id_pc_plus4_2, 32'h0);
      check("wrap valid", {31'd0, if_id_valid2}, 32'd1);

      // asynchronous reset between edges while running
      #2 rst_n = 1'b0;
      #1;
      check("async pc", pc_out, 32'h0);
      check("async instr", if_id_instr, 32'h0);
      check("async valid", {31'd0, if_id_valid}, 32'd0);
      check("async halted", {31'd0, halted}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
